// File: rtl/test_monitor_if.sv
// Snoop bus for test_monitor: test start pulse plus the
// register-file write-back port of the core.
interface test_monitor_if #(
  parameter int CPU_WIDTH = 32
);
  logic                 start;
  logic                 wb_en;
  logic [4:0]           wb_addr;
  logic [CPU_WIDTH-1:0] wb_data;

  modport master (
    output start,
    output wb_en,
    output wb_addr,
    output wb_data
  );

  modport slave (
    input start,
    input wb_en,
    input wb_addr,
    input wb_data
  );
endinterface

// File: rtl/test_monitor.sv
// Test-completion monitor: watches write-back for the done
// handshake, issues pass/fail/timeout verdicts and keeps tallies.
module test_monitor #(
  parameter int CPU_WIDTH      = 32,
  parameter int DONE_REG       = 26,
  parameter int RESULT_REG     = 27,
  parameter int TESTNUM_REG    = 3,
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  test_monitor_if.slave        snoop,
  output logic                 busy,
  output logic                 test_done,
  output logic                 test_pass,
  output logic                 test_fail,
  output logic                 test_timeout,
  output logic [CPU_WIDTH-1:0] fail_testnum,
  output logic [31:0]          cycle_cnt,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic [CNT_W-1:0]     tmo_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_REPORT
  } state_t;

  localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  SET_LD  = 8'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t               r_state;
  logic [7:0]           r_settle;
  logic                 r_tmo;
  logic                 r_pend;
  logic [CPU_WIDTH-1:0] r_res;
  logic [CPU_WIDTH-1:0] r_tn;

  logic w_wr;
  logic w_hit_res;
  logic w_hit_tn;
  logic w_done;
  logic w_limit;

  // x0 is hardwired, so writes to it never count
  assign w_wr      = snoop.wb_en && (snoop.wb_addr != 5'd0);
  assign w_hit_res = w_wr && (snoop.wb_addr == 5'(RESULT_REG));
  assign w_hit_tn  = w_wr && (snoop.wb_addr == 5'(TESTNUM_REG));
  assign w_done    = w_wr && (snoop.wb_addr == 5'(DONE_REG))
                     && (snoop.wb_data == CPU_WIDTH'(1));
  assign w_limit   = (cycle_cnt == TMO_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_settle     <= '0;
      r_tmo        <= 1'b0;
      r_pend       <= 1'b0;
      r_res        <= '0;
      r_tn         <= '0;
      busy         <= 1'b0;
      test_done    <= 1'b0;
      test_pass    <= 1'b0;
      test_fail    <= 1'b0;
      test_timeout <= 1'b0;
      fail_testnum <= '0;
      cycle_cnt    <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      test_done <= 1'b0;
      if (w_hit_res) r_res <= snoop.wb_data;
      if (w_hit_tn)  r_tn  <= snoop.wb_data;

      // a (re)start overrides any shadow write on the same edge
      if (snoop.start && (r_state != S_REPORT)
          || (r_state == S_IDLE && r_pend)) begin
        r_state      <= S_RUN;
        r_tmo        <= 1'b0;
        r_pend       <= 1'b0;
        r_res        <= '0;
        r_tn         <= '0;
        busy         <= 1'b1;
        test_pass    <= 1'b0;
        test_fail    <= 1'b0;
        test_timeout <= 1'b0;
        cycle_cnt    <= '0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_state <= S_IDLE;
          end
          S_RUN: begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (w_done) begin
              r_state  <= S_SETTLE;
              r_settle <= SET_LD;
            end else if (w_limit) begin
              r_state <= S_REPORT;
              r_tmo   <= 1'b1;
            end
          end
          S_SETTLE: begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (r_settle <= 8'd1) begin
              r_state  <= S_REPORT;
              r_settle <= '0;
            end else begin
              r_settle <= r_settle - 8'd1;
            end
          end
          S_REPORT: begin
            r_state   <= S_IDLE;
            r_pend    <= snoop.start;
            busy      <= 1'b0;
            test_done <= 1'b1;
            if (r_tmo) begin
              test_timeout <= 1'b1;
              if (tmo_cnt != CNT_MAX)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else if (r_res == CPU_WIDTH'(1)) begin
              test_pass <= 1'b1;
              if (pass_cnt != CNT_MAX)
                pass_cnt <= pass_cnt + CNT_W'(1);
            end else begin
              test_fail    <= 1'b1;
              fail_testnum <= r_tn;
              if (fail_cnt != CNT_MAX)
                fail_cnt <= fail_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// Scoreboarded bench for test_monitor: expected verdicts are
// queued as tests are driven and checked on each test_done pulse.
module tb_test_monitor;
  localparam int W      = 32;
  localparam int TMO    = 20;
  localparam int CW     = 2;
  localparam int SETTLE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  test_monitor_if #(.CPU_WIDTH(W)) bus ();

  logic          busy, test_done;
  logic          test_pass, test_fail, test_timeout;
  logic [W-1:0]  fail_testnum;
  logic [31:0]   cycle_cnt;
  logic [CW-1:0] pass_cnt, fail_cnt, tmo_cnt;

  test_monitor #(
    .CPU_WIDTH(W), .DONE_REG(26), .RESULT_REG(27),
    .TESTNUM_REG(3), .SETTLE_CYCLES(SETTLE),
    .TIMEOUT_CYCLES(TMO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .snoop(bus.slave),
    .busy(busy), .test_done(test_done),
    .test_pass(test_pass), .test_fail(test_fail),
    .test_timeout(test_timeout),
    .fail_testnum(fail_testnum), .cycle_cnt(cycle_cnt),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .tmo_cnt(tmo_cnt)
  );

  typedef struct {
    logic [2:0]    flags;
    logic [W-1:0]  ftn;
    logic [31:0]   cc;
    logic [CW-1:0] pc, fc, tc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int n_chk = 0;
  int n_fail = 0;
  int edges = 0;
  logic [CW-1:0] m_p = '0, m_f = '0, m_t = '0;
  logic [W-1:0]  m_ftn = '0;

  task automatic cyc(input logic st, input logic en,
                     input logic [4:0] a, input logic [W-1:0] d);
    bus.start = st;
    bus.wb_en = en;
    bus.wb_addr = a;
    bus.wb_data = d;
    @(negedge clk);
    if (st) edges = 0;
    else edges++;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 5'd0, '0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [W-1:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic go();
    cyc(1'b1, 1'b0, 5'd0, '0);
  endtask

  // kind: 0 pass, 1 fail, 2 timeout
  task automatic push(input int kind, input logic [W-1:0] tn,
                      input int cc);
    exp_t e;
    if (kind == 0) begin
      e.flags = 3'b100;
      if (m_p != '1) m_p++;
    end else if (kind == 1) begin
      e.flags = 3'b010;
      m_ftn = tn;
      if (m_f != '1) m_f++;
    end else begin
      e.flags = 3'b001;
      if (m_t != '1) m_t++;
    end
    e.ftn = m_ftn;
    e.cc = 32'(cc);
    e.pc = m_p;
    e.fc = m_f;
    e.tc = m_t;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && test_done) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done: test_done=1 required 0 at %0t",
                 $time);
      end else begin
        mon_e = sbq.pop_front();
        n_chk += 4;
        if ({test_pass, test_fail, test_timeout} !== mon_e.flags) begin
          n_fail++;
          $display("FAIL verdict_flags: got %b required %b",
                   {test_pass, test_fail, test_timeout}, mon_e.flags);
        end
        if (fail_testnum !== mon_e.ftn) begin
          n_fail++;
          $display("FAIL fail_testnum: got %0d required %0d",
                   fail_testnum, mon_e.ftn);
        end
        if (cycle_cnt !== mon_e.cc) begin
          n_fail++;
          $display("FAIL cycle_cnt: got %0d required %0d",
                   cycle_cnt, mon_e.cc);
        end
        if ({pass_cnt, fail_cnt, tmo_cnt} !==
            {mon_e.pc, mon_e.fc, mon_e.tc}) begin
          n_fail++;
          $display("FAIL tallies: got p%0d f%0d t%0d required p%0d f%0d t%0d",
                   pass_cnt, fail_cnt, tmo_cnt,
                   mon_e.pc, mon_e.fc, mon_e.tc);
        end
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_at_done: got %b required 0", busy);
        end
      end
    end
  end

  task automatic chk_drained(input string nm);
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL %s_missing_verdict: pending %0d required 0",
               nm, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    n_chk += 3;
    if ({busy, test_done, test_pass, test_fail, test_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000",
               {busy, test_done, test_pass, test_fail, test_timeout});
    end
    if (fail_testnum !== '0 || cycle_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: ftn %0d cc %0d required 0 0",
               fail_testnum, cycle_cnt);
    end
    if ({pass_cnt, fail_cnt, tmo_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_tallies: got %b required 0",
               {pass_cnt, fail_cnt, tmo_cnt});
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_pass_path();
    go();
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: got %b required 1", busy);
    end
    wr(5'd3, 5);
    wr(5'd27, 1);
    wr(5'd26, 1);
    push(0, '0, edges + SETTLE);
    idle(1);
    n_chk++;
    if (test_done !== 1'b0) begin
      n_fail++;
      $display("FAIL early_done: got %b required 0", test_done);
    end
    idle(2);
    chk_drained("pass");
    n_chk++;
    if ({test_done, test_pass} !== 2'b01) begin
      n_fail++;
      $display("FAIL pass_sticky: got %b required 01",
               {test_done, test_pass});
    end
  endtask

  task automatic test_fail_path();
    go();
    wr(5'd3, 7);
    wr(5'd27, 0);
    wr(5'd26, 2);
    idle(3);
    n_chk++;
    if ({busy, test_fail} !== 2'b10) begin
      n_fail++;
      $display("FAIL non_done_write: busy,fail %b required 10",
               {busy, test_fail});
    end
    wr(5'd26, 1);
    push(1, 7, edges + SETTLE);
    idle(3);
    chk_drained("fail");
  endtask

  task automatic test_late_result();
    int cc;
    go();
    wr(5'd27, 0);
    wr(5'd26, 1);
    cc = edges + SETTLE;
    wr(5'd27, 1);
    push(0, '0, cc);
    idle(3);
    chk_drained("late");
  endtask

  task automatic test_timeout_path();
    go();
    push(2, '0, TMO);
    idle(TMO + 3);
    chk_drained("timeout");
    n_chk++;
    if ({test_timeout, cycle_cnt} !== {1'b1, 32'(TMO)}) begin
      n_fail++;
      $display("FAIL timeout_hold: tmo %b cc %0d required 1 %0d",
               test_timeout, cycle_cnt, TMO);
    end
    go();
    wr(5'd27, 1);
    idle(TMO - 2);
    wr(5'd26, 1);
    push(0, '0, edges + SETTLE);
    idle(3);
    chk_drained("limit_edge");
    n_chk++;
    if (test_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL limit_edge_tmo: got %b required 0", test_timeout);
    end
  endtask

  task automatic test_abort();
    go();
    wr(5'd27, 1);
    go();
    n_chk++;
    if ({busy, test_pass, test_fail, test_timeout,
         pass_cnt, fail_cnt, tmo_cnt} !==
        {4'b1000, m_p, m_f, m_t}) begin
      n_fail++;
      $display("FAIL abort_clear: got b%b p%b f%b t%b tallies %0d %0d %0d",
               busy, test_pass, test_fail, test_timeout,
               pass_cnt, fail_cnt, tmo_cnt);
    end
    wr(5'd26, 1);
    push(1, '0, edges + SETTLE);
    idle(3);
    chk_drained("abort_run");
    go();
    wr(5'd26, 1);
    go();
    idle(3);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_settle_busy: got %b required 1", busy);
    end
  endtask

  task automatic test_start_in_report();
    go();
    wr(5'd26, 1);
    idle(1);
    push(1, '0, edges);
    go();
    edges = -1;
    n_chk++;
    if ({test_done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL report_start: done,busy %b required 10",
               {test_done, busy});
    end
    idle(1);
    n_chk++;
    if ({busy, test_fail} !== 2'b10) begin
      n_fail++;
      $display("FAIL pending_start: busy,fail %b required 10",
               {busy, test_fail});
    end
    wr(5'd27, 1);
    wr(5'd26, 1);
    push(0, '0, edges + SETTLE);
    idle(3);
    chk_drained("report_start");
  endtask

  task automatic test_reset_mid();
    go();
    wr(5'd27, 1);
    wr(5'd26, 1);
    rst_n = 1'b0;
    m_p = '0;
    m_f = '0;
    m_t = '0;
    m_ftn = '0;
    #1;
    n_chk++;
    if ({busy, test_done, test_pass, test_fail, test_timeout,
         fail_testnum, cycle_cnt, pass_cnt, fail_cnt, tmo_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy %b cc %0d tallies %0d %0d %0d",
               busy, cycle_cnt, pass_cnt, fail_cnt, tmo_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    n_chk++;
    if ({busy, test_done, test_pass} !== 3'b000) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b required 000",
               {busy, test_done, test_pass});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      go();
      wr(5'd27, 1);
      wr(5'd26, 1);
      push(0, '0, edges + SETTLE);
      idle(2);
    end
    idle(2);
    chk_drained("b2b");
    n_chk++;
    if (pass_cnt !== 2'd3) begin
      n_fail++;
      $display("FAIL saturation: pass_cnt %0d required 3", pass_cnt);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.wb_en = 1'b0;
    bus.wb_addr = '0;
    bus.wb_data = '0;
    test_reset();
    test_pass_path();
    test_fail_path();
    test_late_result();
    test_timeout_path();
    test_abort();
    test_start_in_report();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
